div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Parametrised multi-cycle radix-2 restoring divider for the pipeline's DIV/DIVU instructions. It is driven by the EX stage and produces a {remainder, quotient} pair, which EX writes to HI/LO. It raises a stall request while it is computing, so the pipeline control holds IF..EX until the result is ready. Operand width and signed/unsigned mode are selectable, and an in-flight division can be annulled when EX is flushed.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (>=4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low
signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
opdata1_i  in  WIDTH  dividend; sampled with start_i
opdata2_i  in  WIDTH  divisor; sampled with start_i
start_i  in  1  request; held high by EX until ready_o is seen
annul_i  in  1  abort the current division (EX flush)
result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
ready_o  out  1  result_o valid
stallreq_o  out  1  divider busy; pipeline must stall

Behaviour:
- States:
  - IDLE: waiting for a request.
  - BY_ZERO: divisor was zero.
  - ON: iterating.
  - END: result available.
- Reset (rst low, asynchronous):
  - state = IDLE, counter = 0, result_o = 0, ready_o = 0, stallreq_o = 0.
  - Reset is immediate, including mid-division.
- IDLE:
  - start_i=1 and annul_i=0, divisor = 0: go to BY_ZERO.
  - start_i=1 and annul_i=0, divisor != 0: go to ON. Latch operand magnitudes (two's-complement negate when signed_div_i=1 and the operand MSB=1), latch both sign bits and the mode, clear the partial remainder, counter = 0.
  - Otherwise stay in IDLE.
- BY_ZERO:
  - Next edge go to END with result_o = 0.
  - If annul_i=1, go to IDLE instead.
- ON:
  - Each edge performs one restoring step: shift {rem, dividend} left by 1; trial = rem - divisor magnitude; if trial >= 0, rem = trial and the quotient LSB = 1, else the quotient LSB = 0. Counter increments.
  - After WIDTH steps, the next edge applies sign correction and goes to END:
    - Quotient is negated if signed and the operand signs differ.
    - Remainder is negated if signed and the dividend is negative.
  - annul_i=1 on any ON edge: go to IDLE; ready_o stays 0 and result_o is not updated.
- END:
  - ready_o = 1 and result_o holds the corrected value.
  - Stay in END while start_i=1.
  - start_i=0: go to IDLE, ready_o = 0, and result_o holds its last value.
  - annul_i in END is ignored.
- stallreq_o = 1 in BY_ZERO and ON, and combinationally in IDLE when start_i=1 and annul_i=0. It is 0 in END and in all other cases.
- Latency (start-capture edge = edge 0):
  - Nonzero divisor: ready_o high after edge WIDTH+1 (33 edges for WIDTH=32).
  - Zero divisor: ready_o high after edge 1.
- Width rules:
  - The partial remainder is WIDTH+1 bits internally (captures the trial sign).
  - Magnitude of the minimum negative value is 2^(W-1) as unsigned.
  - MIN / -1 (signed) gives quotient = MIN (wraps) and remainder = 0. No overflow flag is produced.
- Back-to-back operation: a new start is accepted only from IDLE, i.e. at least one cycle after start_i drops in END.

Test Plan:
- WIDTH=32, unsigned, 100/7, start held -> ready_o after edge 33; result_o = {0x00000002, 0x0000000E}; stallreq_o high during edges 0..32, low once ready_o is high.
- Signed -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- Divisor 0, dividend 0x1234 -> ready_o after edge 1; result_o = 0.
- Abort and reset: annul_i pulsed at edge 10 of a division -> state IDLE, ready_o never rises, result_o unchanged. A new 9/3 then yields quotient 3, remainder 0. rst low mid-ON -> all outputs 0 immediately.
- WIDTH=8 instance, unsigned 200/13 -> ready_o after edge 9; result_o = {0x05, 0x0F}. Start held 5 extra cycles in END -> ready_o stays high and result stable; start drop -> ready_o low next edge.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage <-> divider handshake bundle.
//   master : EX stage (drives request, operands, annul; sees result/ready/stall)
//   slave  : div_unit
// Signals:
//   signed_div_i    1 = DIV (signed), 0 = DIVU
//   opdata1_i       dividend
//   opdata2_i       divisor
//   start_i         request, held until ready_o is seen
//   annul_i         abort in-flight division (EX flush)
//   result_o        {remainder, quotient}
//   ready_o         result_o valid
//   stallreq_o      divider busy, hold IF..EX
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle on operand magnitudes, then a single sign
// correction cycle. Holds the pipeline via stallreq_o while busy.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   div_unit_if.slave (request/operands/annul in, result/ready/stall out)
// Timing (capture edge = 0): nonzero divisor -> ready after edge WIDTH+1,
// zero divisor -> ready after edge 1 with a zero result.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;     // partial remainder (always < divisor)
  logic [WIDTH-1:0]   r_dvd;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvsr;    // divisor magnitude
  logic               r_sgn;
  logic               r_neg1;
  logic               r_neg2;
  logic [2*WIDTH-1:0] r_result;

  logic               w_go;
  logic               w_zero;
  logic               w_done;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_remc;

  assign w_go   = bus.start_i & ~bus.annul_i;
  assign w_zero = (bus.opdata2_i == '0);
  assign w_done = (r_cnt == CNT_W'(WIDTH));

  // Magnitudes: MIN negates to itself, which reads correctly as 2^(W-1) unsigned.
  assign w_mag1 = (bus.signed_div_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign w_mag2 = (bus.signed_div_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // One restoring step. The shifted remainder and trial difference are
  // W+1 bits wide; the trial MSB is the borrow that decides the quotient bit.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvsr};
  assign w_qbit  = ~w_trial[WIDTH];

  // Sign correction: quotient sign = sign1 ^ sign2, remainder follows dividend.
  assign w_quot = (r_sgn & (r_neg1 ^ r_neg2)) ? -r_dvd : r_dvd;
  assign w_remc = (r_sgn & r_neg1)            ? -r_rem : r_rem;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_go) w_next = w_zero ? S_BY_ZERO : S_ON;
      S_BY_ZERO: w_next = bus.annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (bus.annul_i)  w_next = S_IDLE;
        else if (w_done)  w_next = S_END;
      end
      S_END:     if (!bus.start_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs. Stall is combinational in IDLE so the requesting instruction
  // holds in EX on the very cycle it asks; reset forces it low.
  always_comb begin
    bus.ready_o    = (r_state == S_END);
    bus.stallreq_o = rst & ((r_state == S_BY_ZERO) | (r_state == S_ON) |
                            ((r_state == S_IDLE) & w_go));
    bus.result_o   = r_result;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvsr   <= '0;
      r_sgn    <= 1'b0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && !w_zero) begin
            r_dvd  <= w_mag1;
            r_dvsr <= w_mag2;
            r_sgn  <= bus.signed_div_i;
            r_neg1 <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            r_neg2 <= bus.signed_div_i & bus.opdata2_i[WIDTH-1];
            r_rem  <= '0;
            r_cnt  <= '0;
          end
        end
        S_BY_ZERO: begin
          if (!bus.annul_i) r_result <= '0;
        end
        S_ON: begin
          // An annul drops the work in place; result_o keeps the previous answer.
          if (!bus.annul_i) begin
            if (!w_done) begin
              r_rem <= w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
              r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_result <= {w_remc, w_quot};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized + directed bench for div_unit (WIDTH=32 and WIDTH=8).
// Expected results come from plain integer division in the bench; expected
// ready/stall timing comes from the documented latencies.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) b32();
  div_unit_if #(.WIDTH(8))  b8();

  div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  int          n_chk = 0;
  int          n_err = 0;
  logic        exp_rdy [2];
  logic        exp_stl [2];
  logic [63:0] exp_res [2];
  bit          chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer division on w-bit values.
  function automatic logic [63:0] model(int w, bit sg, logic [31:0] a, logic [31:0] b);
    longint m, ua, ub, x, y, q, r;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    if (ub == 0) return 64'd0;
    x = ua; y = ub;
    if (sg) begin
      if (ua >= (longint'(1) << (w-1))) x = ua - (longint'(1) << w);
      if (ub >= (longint'(1) << (w-1))) y = ub - (longint'(1) << w);
    end
    q = x / y;
    r = x % y;
    return ((r & m) << w) | (q & m);
  endfunction

  // Compare process: every cycle, both instances.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdy32", {63'b0, b32.ready_o},    {63'b0, exp_rdy[0]});
      check("stl32", {63'b0, b32.stallreq_o}, {63'b0, exp_stl[0]});
      check("res32", b32.result_o,            exp_res[0]);
      check("rdy8",  {63'b0, b8.ready_o},     {63'b0, exp_rdy[1]});
      check("stl8",  {63'b0, b8.stallreq_o},  {63'b0, exp_stl[1]});
      check("res8",  {48'b0, b8.result_o},    exp_res[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int u, input bit st, input bit an, input bit sg,
                        input logic [31:0] a, input logic [31:0] b);
    if (u == 0) begin
      b32.start_i = st; b32.annul_i = an; b32.signed_div_i = sg;
      b32.opdata1_i = a; b32.opdata2_i = b;
    end else begin
      b8.start_i = st; b8.annul_i = an; b8.signed_div_i = sg;
      b8.opdata1_i = a[7:0]; b8.opdata2_i = b[7:0];
    end
  endtask

  // One transaction. annul_at >= 1 raises annul_i so that edge annul_at aborts.
  task automatic run_div(input int u, input bit sg, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input int annul_at);
    int          w;
    int          lat;
    logic [31:0] bm;
    w   = (u != 0) ? 8 : 32;
    bm  = (u != 0) ? {24'b0, b[7:0]} : b;
    lat = (bm == 0) ? 1 : w + 1;
    set_in(u, 1'b1, 1'b0, sg, a, b);
    exp_stl[u] = 1'b1;
    exp_rdy[u] = 1'b0;
    for (int e = 0; e <= lat; e++) begin
      if (e == annul_at) set_in(u, 1'b1, 1'b1, sg, a, b);
      tick();
      if (e == annul_at) begin
        set_in(u, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_stl[u] = 1'b0;
        exp_rdy[u] = 1'b0;
        tick();
        return;
      end
      if (e < lat) begin
        exp_rdy[u] = 1'b0;
        exp_stl[u] = 1'b1;
      end else begin
        exp_rdy[u] = 1'b1;
        exp_stl[u] = 1'b0;
        exp_res[u] = model(w, sg, a, b);
      end
    end
    repeat (hold) tick();
    set_in(u, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    exp_rdy[u] = 1'b0;
  endtask

  function automatic logic [31:0] pick(int kind);
    case (kind)
      0:       return $urandom;
      1:       return $urandom_range(0, 300);
      2:       return 32'd0;
      3:       return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
      default: return 32'h8000_0000 | {24'b0, 8'($urandom_range(0, 3))};
    endcase
  endfunction

  initial begin
    for (int u = 0; u < 2; u++) begin
      exp_rdy[u] = 1'b0; exp_stl[u] = 1'b0; exp_res[u] = 64'd0;
      set_in(u, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    // Hand-computed values that pin the reference model.
    check("pin_u100_7",   model(32, 1'b0, 32'd100, 32'd7),             64'h00000002_0000000E);
    check("pin_sm7_2",    model(32, 1'b1, 32'hFFFF_FFF9, 32'd2),       64'hFFFFFFFF_FFFFFFFD);
    check("pin_s7_m2",    model(32, 1'b1, 32'd7, 32'hFFFF_FFFE),       64'h00000001_FFFFFFFD);
    check("pin_min_m1",   model(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h00000000_80000000);
    check("pin_umax_1",   model(32, 1'b0, 32'hFFFF_FFFF, 32'd1),       64'h00000000_FFFFFFFF);
    check("pin_div0",     model(32, 1'b0, 32'h1234, 32'd0),            64'd0);
    check("pin_9_3",      model(32, 1'b0, 32'd9, 32'd3),               64'h00000000_00000003);
    check("pin_w8_200_13", model(8, 1'b0, 32'd200, 32'd13),            64'h0000_0000_0000_050F);

    // Reset state observed while rst is held low.
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Directed cases
    run_div(0, 1'b0, 32'd100, 32'd7, 0, -1);
    run_div(0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1, -1);
    run_div(0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, -1);
    run_div(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1);
    run_div(0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, -1);
    run_div(0, 1'b0, 32'h1234, 32'd0, 2, -1);
    run_div(0, 1'b0, 32'd1000, 32'd3, 0, 10);   // annulled: result stays at 0
    run_div(0, 1'b0, 32'd9, 32'd3, 0, -1);
    run_div(1, 1'b0, 32'd200, 32'd13, 5, -1);

    // Asynchronous reset in the middle of an iteration
    set_in(0, 1'b1, 1'b0, 1'b0, 32'd5000, 32'd7);
    exp_stl[0] = 1'b1;
    exp_rdy[0] = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      exp_rdy[u] = 1'b0; exp_stl[u] = 1'b0; exp_res[u] = 64'd0;
    end
    tick();
    set_in(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    tick();

    // Randomized traffic on both widths
    for (int i = 0; i < 60; i++) begin
      int          u;
      int          an;
      bit          sg;
      logic [31:0] a;
      logic [31:0] b;
      u  = (i % 3 == 2) ? 1 : 0;
      sg = 1'($urandom_range(0, 1));
      a  = pick($urandom_range(0, 4));
      b  = pick($urandom_range(0, 4));
      if ($urandom_range(0, 3) != 0 && b == 0) b = $urandom;
      an = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : -1;
      run_div(u, sg, a, b, $urandom_range(0, 3), an);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
